// File: rtl/l1_pulse_gen.sv
// l1_pulse_gen: spaced one-cycle L1 pulse generator, clk250 domain.
// Optional pulse sequence counter output l1_seq when L1_SEQ_EN is defined.
module l1_pulse_gen #(
  parameter int HOLDOFF = 48,
  parameter int PEND_W  = 4
) (
  input  logic              clk250,
  input  logic              rst,
  input  logic              enable,
  input  logic              trig_req,
  input  logic              clr_stats,
  output logic              L1_250MHz,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic [15:0]       dropped_count,
  output logic              overflow
`ifdef L1_SEQ_EN
  ,
  output logic [7:0]        l1_seq
`endif
);

  localparam int CW = $clog2(HOLDOFF);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 2);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [PEND_W-1:0] pend_nx;
  logic              pend_zero;
  logic              pend_full;
  logic              avail;
  logic              launch;
  logic              inc;
  logic              dec;
  logic              drop;

  // Request bookkeeping: the last HOLD cycle counts as a launch slot
  // so back-to-back pulses land exactly HOLDOFF cycles apart.
  always_comb begin
    pend_zero = (pending == '0);
    pend_full = &pending;
    avail     = (state == IDLE) ||
                ((state == HOLD) && (cnt == '0));
    launch    = avail && enable &&
                (trig_req || !pend_zero);
    dec       = launch && !pend_zero;
    inc       = enable && trig_req &&
                !(avail && pend_zero);
    drop      = inc && pend_full && !dec;
    pend_nx   = pending;
    if (!enable)
      pend_nx = '0;
    else if (inc && !dec && !pend_full)
      pend_nx = pending + 1'b1;
    else if (dec && !inc)
      pend_nx = pending - 1'b1;
  end

  // Next-state and holdoff counter logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (launch)
          state_nx = PULSE;
      end
      PULSE: begin
        state_nx = HOLD;
        cnt_nx   = HOLD_LOAD;
      end
      HOLD: begin
        if (cnt == '0)
          state_nx = launch ? PULSE : IDLE;
        else
          cnt_nx = cnt - 1'b1;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register and holdoff counter.
  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Registered outputs, updated alongside the state.
  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      L1_250MHz <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
    end else begin
      L1_250MHz <= (state_nx == PULSE);
      busy      <= (state_nx != IDLE) ||
                   (pend_nx != '0);
      pending   <= pend_nx;
    end
  end

  // Drop statistics; a clear in the same cycle as a drop wins.
  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      dropped_count <= '0;
      overflow      <= 1'b0;
    end else if (clr_stats) begin
      dropped_count <= '0;
      overflow      <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped_count != 16'hFFFF)
        dropped_count <= dropped_count + 1'b1;
    end
  end

`ifdef L1_SEQ_EN
  // Issued pulse count, wrapping, ticks with each L1 pulse.
  always_ff @(posedge clk250 or posedge rst) begin
    if (rst)
      l1_seq <= '0;
    else if (state_nx == PULSE)
      l1_seq <= l1_seq + 1'b1;
  end
`endif

endmodule

// File: tb/tb_l1_pulse_gen.sv
// tb_l1_pulse_gen: directed scoreboard bench for l1_pulse_gen.
// Expected pulse cycles are queued at stimulus time and popped per pulse.
`timescale 1ns/100ps
module tb_l1_pulse_gen;

  localparam int HOLDOFF = 48;
  localparam int PEND_W  = 4;

  logic              clk250 = 1'b0;
  logic              rst;
  logic              enable;
  logic              trig_req;
  logic              clr_stats;
  logic              L1_250MHz;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic [15:0]       dropped_count;
  logic              overflow;
`ifdef L1_SEQ_EN
  logic [7:0]        l1_seq;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_q[$];
  int base;

  l1_pulse_gen #(
    .HOLDOFF (HOLDOFF),
    .PEND_W  (PEND_W)
  ) dut (
    .clk250        (clk250),
    .rst           (rst),
    .enable        (enable),
    .trig_req      (trig_req),
    .clr_stats     (clr_stats),
    .L1_250MHz     (L1_250MHz),
    .busy          (busy),
    .pending       (pending),
    .dropped_count (dropped_count),
    .overflow      (overflow)
`ifdef L1_SEQ_EN
    ,
    .l1_seq        (l1_seq)
`endif
  );

  always #5 clk250 = ~clk250;

  always @(posedge clk250) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk250);
    #1;
  endtask

  // Scoreboard: every pulse must match the next queued cycle.
  always @(negedge clk250) begin
    if (!rst && L1_250MHz === 1'b1) begin
      if (exp_q.size() == 0)
        chk("unexpected_pulse", cyc, 32'hFFFF_FFFF);
      else
        chk("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    trig_req  = 1'b0;
    clr_stats = 1'b0;
    step(3);
    chk("rst_l1", L1_250MHz, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_dropped", dropped_count, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    step(2);
    enable = 1'b1;
    step(2);

    // single request
    base = cyc;
    trig_req = 1'b1;
    exp_q.push_back(base + 1);
    step(1);
    trig_req = 1'b0;
    chk("t1_busy_first", busy, 1);
    chk("t1_pending", pending, 0);
    step(47);
    chk("t1_busy_last", busy, 1);
    step(1);
    chk("t1_busy_clear", busy, 0);
    chk("t1_pending_end", pending, 0);
    step(3);

    // three consecutive requests
    base = cyc;
    trig_req = 1'b1;
    exp_q.push_back(base + 1);
    exp_q.push_back(base + 1 + HOLDOFF);
    exp_q.push_back(base + 1 + 2 * HOLDOFF);
    step(2);
    chk("t2_pending1", pending, 1);
    step(1);
    trig_req = 1'b0;
    chk("t2_pending2", pending, 2);
    step(46);
    chk("t2_pending_dec1", pending, 1);
    step(48);
    chk("t2_pending_dec0", pending, 0);
    chk("t2_busy_hold", busy, 1);
    step(49);
    chk("t2_busy_clear", busy, 0);
    chk("t2_dropped", dropped_count, 0);
    chk("t2_overflow", overflow, 0);

    // held request saturates the queue
    base = cyc;
    trig_req = 1'b1;
    for (int k = 0; k < 16; k++)
      exp_q.push_back(base + 1 + k * HOLDOFF);
    step(40);
    trig_req = 1'b0;
    chk("t3_pending_sat", pending, 15);
    chk("t3_dropped", dropped_count, 24);
    chk("t3_overflow", overflow, 1);
    step(15 * HOLDOFF - 39);
    chk("t3_pending_end", pending, 0);
    step(HOLDOFF + 1);
    chk("t3_busy_clear", busy, 0);
    chk("t3_all_pulses", exp_q.size(), 0);
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0;
    chk("t3_clr_dropped", dropped_count, 0);
    chk("t3_clr_overflow", overflow, 0);
    step(2);

    // disable mid-HOLD with pending requests
    base = cyc;
    trig_req = 1'b1;
    exp_q.push_back(base + 1);
    step(6);
    trig_req = 1'b0;
    chk("t4_pending5", pending, 5);
    step(4);
    enable = 1'b0;
    step(1);
    chk("t4_flush", pending, 0);
    step(1);
    trig_req = 1'b1;
    step(3);
    trig_req = 1'b0;
    chk("t4_ign_pending", pending, 0);
    chk("t4_ign_dropped", dropped_count, 0);
    step(33);
    chk("t4_hold_busy", busy, 1);
    step(1);
    chk("t4_hold_done", busy, 0);
    step(10);
    enable = 1'b1;
    step(10);
    chk("t4_no_pulse", L1_250MHz, 0);
    chk("t4_idle", busy, 0);

    // async reset mid-HOLD with pending requests
    base = cyc;
    trig_req = 1'b1;
    exp_q.push_back(base + 1);
    step(4);
    trig_req = 1'b0;
    chk("t5_pending3", pending, 3);
    step(10);
    rst = 1'b1;
    #1;
    chk("t5_rst_l1", L1_250MHz, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pending", pending, 0);
    chk("t5_rst_dropped", dropped_count, 0);
    chk("t5_rst_overflow", overflow, 0);
    step(2);
    rst = 1'b0;
    step(1);
    base = cyc;
    trig_req = 1'b1;
    exp_q.push_back(base + 1);
    step(1);
    trig_req = 1'b0;
    chk("t5_pulse_now", L1_250MHz, 1);
    chk("t5_pending_post", pending, 0);
    step(HOLDOFF + 2);
    chk("t5_busy_clear", busy, 0);

`ifdef L1_SEQ_EN
    // sequence counter wrap
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_seq_rst", l1_seq, 0);
    step(1);
    for (int k = 0; k < 257; k++) begin
      trig_req = 1'b1;
      exp_q.push_back(cyc + 1);
      step(1);
      trig_req = 1'b0;
      step(HOLDOFF);
    end
    chk("t6_seq_wrap", l1_seq, 1);
`endif

    step(2);
    chk("all_pulses_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
